// File: rtl/deparse_hdr_writer.sv
// deparse_hdr_writer
//
// Rebuilds a packet header by overwriting selected bytes of the original
// header with field values produced by the upstream field extractors.
// Processes one header at a time: load (IDLE), merge field writes (MERGE),
// present the result (OUTPUT).
//
// Handshake semantics (both hdr_in and hdr_out): a transfer happens on a
// rising clk edge where valid and ready are both 1. valid, once raised by the
// producer, is held with stable data until that transfer. The ready signals
// here are decoded from the state register only, never from inputs.
//
// Ports:
//   clk, areset                     clock, async active-high reset
//   hdr_in_valid/hdr_in_ready/hdr_in    original header (byte i at [8*i +: 8])
//   val_in_valid, val_in, val_in_type,
//   val_in_offset, val_in_last      field write stream (type 01=2B,10=4B,11=6B,00=no-op)
//   hdr_out_valid/hdr_out_ready/hdr_out rebuilt header
//   wr_cnt                          applied field writes for this header (saturates at 15)
//   ovf_err                         some field bytes fell past the last header byte
module deparse_hdr_writer #(
    parameter int C_HDR_WIDTH    = 1024,
    parameter int C_OFFSET_WIDTH = 7
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      hdr_in_valid,
    output logic                      hdr_in_ready,
    input  logic [C_HDR_WIDTH-1:0]    hdr_in,
    input  logic                      val_in_valid,
    input  logic [47:0]               val_in,
    input  logic [1:0]                val_in_type,
    input  logic [C_OFFSET_WIDTH-1:0] val_in_offset,
    input  logic                      val_in_last,
    output logic                      hdr_out_valid,
    input  logic                      hdr_out_ready,
    output logic [C_HDR_WIDTH-1:0]    hdr_out,
    output logic [3:0]                wr_cnt,
    output logic                      ovf_err
);

    localparam int NBYTES = C_HDR_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MERGE  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [C_HDR_WIDTH-1:0] buf_nxt;
    logic                   ovf_hit;
    logic                   wr_en;
    int                     fld_len;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and state-decoded handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        hdr_in_ready  = 1'b0;
        hdr_out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hdr_in_ready = 1'b1;
                if (hdr_in_valid) begin
                    state_d = ST_MERGE;
                end
            end
            ST_MERGE: begin
                if (val_in_last) begin
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                hdr_out_valid = 1'b1;
                if (hdr_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Field merge: value byte j (j=0 is the field's MS byte) lands on
    // header byte offset+j. Bytes past the end of the header are dropped
    // and flagged; the in-range bytes of the same field still land.
    // ------------------------------------------------------------------
    always_comb begin
        buf_nxt = hdr_out;
        ovf_hit = 1'b0;
        case (val_in_type)
            2'b01:   fld_len = 2;
            2'b10:   fld_len = 4;
            2'b11:   fld_len = 6;
            default: fld_len = 0;
        endcase
        for (int j = 0; j < 6; j++) begin
            if (j < fld_len) begin
                if (int'(val_in_offset) + j < NBYTES) begin
                    buf_nxt[8*(int'(val_in_offset) + j) +: 8] = val_in[8*(fld_len - 1 - j) +: 8];
                end else begin
                    ovf_hit = 1'b1;
                end
            end
        end
    end

    // Type 00 is a no-op: it neither touches the buffer nor counts.
    assign wr_en = (state_q == ST_MERGE) && val_in_valid && (val_in_type != 2'b00);

    // ------------------------------------------------------------------
    // Header buffer and per-header status. The buffer register drives
    // hdr_out directly, so the output is held stable through OUTPUT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            hdr_out <= '0;
            wr_cnt  <= 4'd0;
            ovf_err <= 1'b0;
        end else if (state_q == ST_IDLE && hdr_in_valid) begin
            hdr_out <= hdr_in;
            wr_cnt  <= 4'd0;
            ovf_err <= 1'b0;
        end else if (wr_en) begin
            hdr_out <= buf_nxt;
            if (wr_cnt != 4'hF) begin
                wr_cnt <= wr_cnt + 4'd1;
            end
            if (ovf_hit) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_deparse_hdr_writer.sv
module tb_deparse_hdr_writer;

  localparam int HW = 1024;
  localparam int OW = 7;
  localparam int NB = HW / 8;
  localparam int EW = HW + 5;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          areset;
  logic          hdr_in_valid;
  logic          hdr_in_ready;
  logic [HW-1:0] hdr_in;
  logic          val_in_valid;
  logic [47:0]   val_in;
  logic [1:0]    val_in_type;
  logic [OW-1:0] val_in_offset;
  logic          val_in_last;
  logic          hdr_out_valid;
  logic          hdr_out_ready;
  logic [HW-1:0] hdr_out;
  logic [3:0]    wr_cnt;
  logic          ovf_err;

  int checks = 0;
  int errors = 0;

  // reference model state for the header being built
  logic [HW-1:0] m_hdr;
  logic [3:0]    m_cnt;
  logic          m_ovf;
  // scoreboard: {ovf, cnt, header} expected per completed header
  logic [EW-1:0] exp_q[$];

  deparse_hdr_writer #(.C_HDR_WIDTH(HW), .C_OFFSET_WIDTH(OW)) dut (
    .clk           (clk),
    .areset        (areset),
    .hdr_in_valid  (hdr_in_valid),
    .hdr_in_ready  (hdr_in_ready),
    .hdr_in        (hdr_in),
    .val_in_valid  (val_in_valid),
    .val_in        (val_in),
    .val_in_type   (val_in_type),
    .val_in_offset (val_in_offset),
    .val_in_last   (val_in_last),
    .hdr_out_valid (hdr_out_valid),
    .hdr_out_ready (hdr_out_ready),
    .hdr_out       (hdr_out),
    .wr_cnt        (wr_cnt),
    .ovf_err       (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hdr_in_valid  = 1'b0;
    hdr_in        = '0;
    val_in_valid  = 1'b0;
    val_in        = '0;
    val_in_type   = 2'b00;
    val_in_offset = '0;
    val_in_last   = 1'b0;
    hdr_out_ready = 1'b0;
  endtask

  function automatic logic [HW-1:0] rand_hdr();
    logic [HW-1:0] r;
    for (int i = 0; i < HW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [47:0] rand_val();
    logic [47:0] r;
    r[31:0]  = $urandom;
    r[47:32] = 16'($urandom);
    return r;
  endfunction

  // Model: a field is a list of bytes, most-significant first; byte k goes
  // to header byte off+k if that byte exists.
  task automatic model_write(input logic [1:0] t, input logic [47:0] v, input int off);
    logic [7:0]  fld[$];
    logic [47:0] tmp;
    int          len;
    len = (t == 2'b01) ? 2 : (t == 2'b10) ? 4 : (t == 2'b11) ? 6 : 0;
    tmp = v;
    for (int k = 0; k < len; k++) begin
      fld.push_front(tmp[7:0]);
      tmp = tmp >> 8;
    end
    for (int k = 0; k < len; k++) begin
      if (off + k < NB) m_hdr[8*(off + k) +: 8] = fld[k];
      else m_ovf = 1'b1;
    end
    if (len > 0 && m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
  endtask

  task automatic load_hdr(input logic [HW-1:0] h);
    checks++;
    if (hdr_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready: hdr_in_ready=%b expected 1", hdr_in_ready);
    end
    hdr_in       = h;
    hdr_in_valid = 1'b1;
    step();
    hdr_in_valid = 1'b0;
    m_hdr = h;
    m_cnt = 4'd0;
    m_ovf = 1'b0;
    checks++;
    if (hdr_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_busy: hdr_in_ready=%b expected 0", hdr_in_ready);
    end
  endtask

  task automatic drive_field(input logic vld, input logic [1:0] t, input logic [47:0] v,
                             input int off, input logic last);
    val_in_valid  = vld;
    val_in_type   = t;
    val_in        = v;
    val_in_offset = off[OW-1:0];
    val_in_last   = last;
    if (last) begin
      checks++;
      if (hdr_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL pre_last_valid: hdr_out_valid=%b expected 0", hdr_out_valid);
      end
    end
    step();
    val_in_valid = 1'b0;
    val_in_last  = 1'b0;
    val_in_type  = 2'b00;
    if (vld) model_write(t, v, off);
    if (last) begin
      exp_q.push_back({m_ovf, m_cnt, m_hdr});
      checks++;
      if (hdr_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL out_valid_latency: hdr_out_valid=%b expected 1", hdr_out_valid);
      end
    end
  endtask

  // Hold ready low for 'stall' cycles while driving noise, then handshake.
  task automatic collect(input int stall);
    logic [EW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: size=0 expected >0");
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < stall; i++) begin
      val_in_valid  = 1'b1;
      val_in_type   = 2'($urandom_range(1, 3));
      val_in        = rand_val();
      val_in_offset = OW'($urandom_range(0, NB - 1));
      val_in_last   = 1'($urandom_range(0, 1));
      hdr_in_valid  = 1'b1;
      hdr_in        = rand_hdr();
      step();
      checks++;
      if (hdr_out !== e[HW-1:0] || hdr_in_ready !== 1'b0 || hdr_out_valid !== 1'b1 ||
          wr_cnt !== e[HW+3:HW] || ovf_err !== e[HW+4]) begin
        errors++;
        $display("FAIL stall_hold: ready=%b valid=%b cnt=%0d ovf=%b expected ready=0 valid=1 cnt=%0d ovf=%b, hdr_match=%b",
                 hdr_in_ready, hdr_out_valid, wr_cnt, ovf_err, e[HW+3:HW], e[HW+4], hdr_out === e[HW-1:0]);
      end
    end
    val_in_valid = 1'b0;
    val_in_last  = 1'b0;
    hdr_in_valid = 1'b0;
    checks++;
    if (hdr_out !== e[HW-1:0]) begin
      errors++;
      $display("FAIL hdr_out: got %h expected %h", hdr_out, e[HW-1:0]);
    end
    checks++;
    if (wr_cnt !== e[HW+3:HW]) begin
      errors++;
      $display("FAIL wr_cnt: got %0d expected %0d", wr_cnt, e[HW+3:HW]);
    end
    checks++;
    if (ovf_err !== e[HW+4]) begin
      errors++;
      $display("FAIL ovf_err: got %b expected %b", ovf_err, e[HW+4]);
    end
    hdr_out_ready = 1'b1;
    step();
    hdr_out_ready = 1'b0;
    checks++;
    if (hdr_in_ready !== 1'b1 || hdr_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL out_handshake: ready=%b valid=%b expected ready=1 valid=0", hdr_in_ready, hdr_out_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    areset = 1'b1;
    idle_inputs();
    repeat (3) step();
    checks++;
    if (hdr_in_ready !== 1'b1 || hdr_out_valid !== 1'b0 || wr_cnt !== 4'd0 || ovf_err !== 1'b0 || hdr_out !== '0) begin
      errors++;
      $display("FAIL reset_held: ready=%b valid=%b cnt=%0d ovf=%b hdr_zero=%b expected 1 0 0 0 1",
               hdr_in_ready, hdr_out_valid, wr_cnt, ovf_err, hdr_out === '0);
    end
    #2 areset = 1'b0;
    step();
    checks++;
    if (hdr_in_ready !== 1'b1 || hdr_out_valid !== 1'b0 || hdr_out !== '0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b hdr_zero=%b expected 1 0 1",
               hdr_in_ready, hdr_out_valid, hdr_out === '0);
    end
  endtask

  task automatic test_basic_2b();
    load_hdr('0);
    drive_field(1'b1, 2'b01, 48'h0000_0000_ABCD, 12, 1'b1);
    checks++;
    if (hdr_out[8*12 +: 16] !== 16'hCDAB || wr_cnt !== 4'd1 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_2b: bytes12_13=%h cnt=%0d ovf=%b expected cdab 1 0", hdr_out[8*12 +: 16], wr_cnt, ovf_err);
    end
    collect(0);
  endtask

  task automatic test_overflow();
    load_hdr({HW{1'b1}});
    drive_field(1'b1, 2'b11, 48'h1122_3344_5566, 126, 1'b1);
    checks++;
    if (hdr_out[8*126 +: 16] !== 16'h2211 || ovf_err !== 1'b1 || wr_cnt !== 4'd1) begin
      errors++;
      $display("FAIL overflow: bytes126_127=%h ovf=%b cnt=%0d expected 2211 1 1", hdr_out[8*126 +: 16], ovf_err, wr_cnt);
    end
    collect(0);
  endtask

  task automatic test_overlap();
    load_hdr(rand_hdr());
    drive_field(1'b1, 2'b10, 48'h0000_DEAD_BEEF, 0, 1'b0);
    drive_field(1'b1, 2'b01, 48'h0000_0000_1234, 2, 1'b0);
    drive_field(1'b1, 2'b00, rand_val(), 0, 1'b0);
    drive_field(1'b0, 2'b00, 48'h0, 0, 1'b1);
    checks++;
    if (hdr_out[31:0] !== 32'h3412_ADDE || wr_cnt !== 4'd2) begin
      errors++;
      $display("FAIL overlap: bytes0_3=%h cnt=%0d expected 3412adde 2", hdr_out[31:0], wr_cnt);
    end
    collect(0);
  endtask

  task automatic test_backpressure();
    logic [HW-1:0] prev;
    logic [3:0]    prev_cnt;
    load_hdr(rand_hdr());
    drive_field(1'b1, 2'b11, rand_val(), 125, 1'b0);
    drive_field(1'b1, 2'b10, rand_val(), 40, 1'b0);
    drive_field(1'b1, 2'b01, rand_val(), 41, 1'b1);
    collect(5);
    // field writes while idle must leave the buffer alone
    prev     = hdr_out;
    prev_cnt = wr_cnt;
    val_in_valid  = 1'b1;
    val_in_type   = 2'b11;
    val_in        = rand_val();
    val_in_offset = 7'd0;
    step();
    val_in_valid = 1'b0;
    checks++;
    if (hdr_out !== prev || wr_cnt !== prev_cnt || hdr_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ignore: cnt=%0d ready=%b hdr_same=%b expected cnt=%0d ready=1 hdr_same=1",
               wr_cnt, hdr_in_ready, hdr_out === prev, prev_cnt);
    end
    load_hdr(rand_hdr());
    drive_field(1'b0, 2'b00, 48'h0, 0, 1'b1);
    collect(0);
  endtask

  task automatic test_reset_mid();
    load_hdr(rand_hdr());
    for (int i = 0; i < 3; i++)
      drive_field(1'b1, 2'($urandom_range(1, 3)), rand_val(), $urandom_range(0, NB - 1), 1'b0);
    areset = 1'b1;
    #1;
    checks++;
    if (hdr_in_ready !== 1'b1 || hdr_out_valid !== 1'b0 || wr_cnt !== 4'd0 || ovf_err !== 1'b0 || hdr_out !== '0) begin
      errors++;
      $display("FAIL reset_async: ready=%b valid=%b cnt=%0d ovf=%b hdr_zero=%b expected 1 0 0 0 1",
               hdr_in_ready, hdr_out_valid, wr_cnt, ovf_err, hdr_out === '0);
    end
    #3 areset = 1'b0;
    step();
    load_hdr(rand_hdr());
    drive_field(1'b1, 2'b10, rand_val(), 64, 1'b0);
    drive_field(1'b1, 2'b01, rand_val(), 127, 1'b1);
    collect(1);
  endtask

  task automatic test_saturate();
    load_hdr(rand_hdr());
    for (int i = 0; i < 16; i++)
      drive_field(1'b1, 2'($urandom_range(1, 3)), rand_val(), $urandom_range(0, NB - 1), 1'b0);
    drive_field(1'b0, 2'b00, 48'h0, 0, 1'b1);
    checks++;
    if (wr_cnt !== 4'd15) begin
      errors++;
      $display("FAIL saturate: wr_cnt=%0d expected 15", wr_cnt);
    end
    collect(0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int nw;
      load_hdr(rand_hdr());
      nw = $urandom_range(0, 10);
      for (int i = 0; i < nw; i++) begin
        int off;
        off = ($urandom_range(0, 3) == 0) ? $urandom_range(NB - 8, NB - 1) : $urandom_range(0, NB - 1);
        drive_field(1'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), rand_val(), off, 1'b0);
      end
      if ($urandom_range(0, 1) == 1)
        drive_field(1'b1, 2'($urandom_range(0, 3)), rand_val(), $urandom_range(0, NB - 1), 1'b1);
      else
        drive_field(1'b0, 2'b00, 48'h0, 0, 1'b1);
      collect($urandom_range(0, 3));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic_2b();
    test_overflow();
    test_overlap();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: size=%0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/deparse_hdr_writer.md
Name: deparse_hdr_writer

Overview:
- Sits directly downstream of the sub-deparser field extractors.
- Takes the original packet header plus a stream of extracted field values (2B/4B/6B, each with a byte offset) and overwrites those bytes in a header buffer.
- Presents the rebuilt header to the packet output stage through a valid/ready handshake.
- Handles exactly one header at a time via a three-state FSM.

Parameters:
- C_HDR_WIDTH, 1024: header buffer width in bits (128 bytes); must be a multiple of 8.
- C_OFFSET_WIDTH, 7: width of the byte offset; 2^C_OFFSET_WIDTH == C_HDR_WIDTH/8.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- areset  in  1  asynchronous, active-high reset.
- hdr_in_valid  in  1  original header available.
- hdr_in_ready  out  1  block can accept a header.
- hdr_in  in  C_HDR_WIDTH  original header; byte i at bits [8*i +: 8].
- val_in_valid  in  1  field write valid.
- val_in  in  48  field value, right-aligned (2B uses [15:0], 4B uses [31:0]).
- val_in_type  in  2  01=2B, 10=4B, 11=6B, 00=no-op.
- val_in_offset  in  C_OFFSET_WIDTH  header byte receiving the field's most-significant byte.
- val_in_last  in  1  last field write for this header; may be asserted with or without val_in_valid.
- hdr_out_valid  out  1  rebuilt header valid.
- hdr_out_ready  in  1  downstream accepts the header.
- hdr_out  out  C_HDR_WIDTH  rebuilt header.
- wr_cnt  out  4  field writes applied for the current header; saturates at 15.
- ovf_err  out  1  sticky per header: some field bytes fell beyond the last header byte.

Behaviour:
- Reset (async assert; release sampled on clk): state IDLE, hdr_in_ready=1, hdr_out_valid=0, hdr_out=0, wr_cnt=0, ovf_err=0.
- Reset mid-operation discards any header in progress; no partial output.
- States:
  - IDLE: hdr_in_ready=1. On hdr_in_valid, load hdr_in into the buffer, clear wr_cnt and ovf_err, go MERGE. hdr_in_ready=0 from the next cycle.
  - MERGE: accept one field write per cycle when val_in_valid=1. Field length L = 2/4/6 bytes for type 01/10/11.
    - Value byte j (j=0 is the most-significant byte of the L-byte field) goes to header byte offset+j.
    - Bytes with offset+j > 2^C_OFFSET_WIDTH-1 are dropped and set ovf_err; in-range bytes of the same field are still written.
    - Each write with type != 00 increments wr_cnt (saturating at 15). Type 00 changes nothing.
    - Overlapping writes: the later write wins. The write is visible in the buffer the next cycle.
    - On val_in_last=1, go OUTPUT. If val_in_valid is also 1, that write is applied first and is included in hdr_out.
  - OUTPUT: hdr_out_valid=1; hdr_out, wr_cnt and ovf_err held stable. Field inputs are ignored.
    - On hdr_out_valid && hdr_out_ready, go IDLE; hdr_out_valid=0 and hdr_in_ready=1 the next cycle.
- Field inputs in IDLE are ignored. hdr_in_valid outside IDLE is not accepted (ready=0).
- Latency:
  - hdr_in handshake at cycle t: earliest field write at t+1.
  - val_in_last at cycle t: hdr_out_valid at t+1.
  - Minimum header-in to header-out latency is 2 cycles (last at t+1 with no writes).
- hdr_out is a register; no combinational path from inputs to outputs except none (hdr_in_ready is state-decoded).

Test Plan:
- Zero header, write 2B val_in=0x00000000ABCD at offset 12, last in the same cycle -> hdr_out byte12=0xAB, byte13=0xCD, all other bytes 0; wr_cnt=1; ovf_err=0; hdr_out_valid exactly 1 cycle after last.
- Header all 0xFF; 6B 0x112233445566 at offset 126 -> byte126=0x11, byte127=0x22, rest 0xFF; ovf_err=1; wr_cnt=1.
- 4B 0xDEADBEEF at offset 0, then 2B 0x1234 at offset 2, then type 00 at offset 0, then last -> bytes0..3 = DE AD 12 34; wr_cnt=2.
- Hold hdr_out_ready=0 for 5 cycles in OUTPUT while driving field writes and hdr_in_valid -> hdr_out stable, hdr_in_ready=0; after the ready handshake, hdr_in_ready=1 next cycle and a new header loads with wr_cnt and ovf_err cleared.
- Assert areset during MERGE after 3 writes -> outputs return to reset values immediately (async); after release, a new header yields output with no residue from the aborted one.
- 16 writes before last -> wr_cnt=15 (saturated).
